// File: rtl/dtc_vote_if.sv
// Label-in / vote-out handshake bundle between a tree classifier and the vote accumulator.
// The slave modport is used by dtc_vote_accum; master is the upstream/downstream side.
interface dtc_vote_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_class;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_class;
    logic [CNT_W-1:0] out_count;
    logic             out_tie;
    logic             busy;

    modport master (
        output in_valid, in_class, flush, out_ready,
        input  in_ready, out_valid, out_class, out_count, out_tie, busy
    );

    modport slave (
        input  in_valid, in_class, flush, out_ready,
        output in_ready, out_valid, out_class, out_count, out_tie, busy
    );
endinterface

// File: rtl/dtc_vote_accum.sv
// Majority vote over a window of 3-bit class labels; result 8 cycles after the window closes.
// in_ready drops while scanning/holding; the result is held until out_ready.
module dtc_vote_accum #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    dtc_vote_if.slave    vif
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]        samp_q, samp_d;
    logic [2:0]              idx_q, idx_d;
    logic [2:0]              best_cls_q, best_cls_d;
    logic [CNT_W-1:0]        best_cnt_q, best_cnt_d;
    logic                    best_tie_q, best_tie_d;
    logic [2:0]              out_class_q, out_class_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_tie_q, out_tie_d;
    logic                    rdy_en_q, rdy_en_d;

    logic                    accept;
    logic                    last_sample;
    logic [CNT_W-1:0]        cur_cnt;

    assign vif.in_ready  = rdy_en_q && (state_q == ST_ACCUM);
    assign vif.out_valid = (state_q == ST_HOLD);
    assign vif.busy      = (state_q != ST_ACCUM);
    assign vif.out_class = out_class_q;
    assign vif.out_count = out_count_q;
    assign vif.out_tie   = out_tie_q;

    assign accept      = vif.in_valid && vif.in_ready;
    assign last_sample = (samp_q == CNT_W'(WINDOW - 1));
    assign cur_cnt     = cnt_q[idx_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        samp_d      = samp_q;
        idx_d       = idx_q;
        best_cls_d  = best_cls_q;
        best_cnt_d  = best_cnt_q;
        best_tie_d  = best_tie_q;
        out_class_d = out_class_q;
        out_count_d = out_count_q;
        out_tie_d   = out_tie_q;
        rdy_en_d    = 1'b1;

        unique case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    cnt_d[vif.in_class] = cnt_q[vif.in_class] + 1'b1;
                    samp_d              = samp_q + 1'b1;
                end
                // A flush on an empty window is dropped unless it carries a label itself.
                if ((accept && last_sample) ||
                    (vif.flush && (accept || (samp_q != '0)))) begin
                    state_d = ST_SCAN;
                    idx_d   = 3'd0;
                end
            end
            ST_SCAN: begin
                // Strictly-greater replacement keeps the lowest index on ties.
                if ((idx_q == 3'd0) || (cur_cnt > best_cnt_q)) begin
                    best_cls_d = idx_q;
                    best_cnt_d = cur_cnt;
                    best_tie_d = 1'b0;
                end else if (cur_cnt == best_cnt_q) begin
                    best_tie_d = 1'b1;
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d     = ST_HOLD;
                    out_class_d = best_cls_d;
                    out_count_d = best_cnt_d;
                    out_tie_d   = best_tie_d;
                end
            end
            ST_HOLD: begin
                if (vif.out_ready) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    samp_d  = '0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            samp_q      <= '0;
            idx_q       <= '0;
            best_cls_q  <= '0;
            best_cnt_q  <= '0;
            best_tie_q  <= 1'b0;
            out_class_q <= '0;
            out_count_q <= '0;
            out_tie_q   <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            idx_q       <= idx_d;
            best_cls_q  <= best_cls_d;
            best_cnt_q  <= best_cnt_d;
            best_tie_q  <= best_tie_d;
            out_class_q <= out_class_d;
            out_count_q <= out_count_d;
            out_tie_q   <= out_tie_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule
